// File: rtl/pat_pkg.sv
// Shared defaults and load-FSM state encoding for the pattern buffer and PAT core.
package pat_pkg;
  localparam int D_WIDTH_DEF      = 8;
  localparam int BUFP_WIDTH_DEF   = 3;
  localparam int FIELDP_WIDTH_DEF = 5;
  localparam int LOAD_WIDTH_DEF   = 4;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;
endpackage

// File: rtl/pattern_load_ctrl.sv
// Bulk-load sequencer: FSM, beat counter, load write address and PAT write gating.
// Handshake: a beat transfers on a rising edge where ld_valid && ld_ready; ld_valid may drop at any time.
module pattern_load_ctrl
  import pat_pkg::*;
#(
  parameter int BUFP_WIDTH   = BUFP_WIDTH_DEF,
  parameter int FIELDP_WIDTH = FIELDP_WIDTH_DEF,
  parameter int LOAD_WIDTH   = LOAD_WIDTH_DEF,
  localparam int ADDR_W      = BUFP_WIDTH + FIELDP_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_start,
  input  logic [BUFP_WIDTH-1:0] ld_buf,
  input  logic                  ld_valid,
  input  logic                  write_en,
  input  logic [BUFP_WIDTH-1:0] write_buf,
  output logic                  ld_ready,
  output logic                  ld_busy,
  output logic                  ld_done,
  output logic                  start_take,
  output logic                  load_we,
  output logic [ADDR_W-1:0]     load_addr,
  output logic                  last_beat,
  output logic                  pat_we,
  output logic                  conflict,
  output logic [BUFP_WIDTH-1:0] load_buf,
  output ld_state_t             state
);
  localparam int NFIELD = 1 << FIELDP_WIDTH;
  localparam int NBEAT  = NFIELD / LOAD_WIDTH;
  localparam int BEAT_W = $clog2(NBEAT);
  localparam int LANE_W = $clog2(LOAD_WIDTH);

  logic [BEAT_W-1:0] cnt;

  assign start_take = ld_start && (state == LD_IDLE);
  assign load_we    = ld_valid && ld_ready;
  assign last_beat  = load_we && (cnt == BEAT_W'(NBEAT - 1));
  // Lane bits of the address are zero; the storage adds the lane index.
  assign load_addr  = ADDR_W'({load_buf, cnt}) << LANE_W;
  assign conflict   = write_en && ld_busy && (write_buf == load_buf);
  assign pat_we     = write_en && !conflict;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LD_IDLE;
      cnt      <= '0;
      load_buf <= '0;
      ld_ready <= 1'b0;
      ld_busy  <= 1'b0;
      ld_done  <= 1'b0;
    end else begin
      case (state)
        LD_IDLE: begin
          ld_done <= 1'b0;
          if (start_take) begin
            load_buf <= ld_buf;
            cnt      <= '0;
            ld_ready <= 1'b1;
            ld_busy  <= 1'b1;
            state    <= LD_LOAD;
          end
        end
        LD_LOAD: begin
          if (load_we) begin
            // Counter parks on the final beat instead of wrapping.
            if (last_beat) begin
              ld_ready <= 1'b0;
              ld_busy  <= 1'b0;
              ld_done  <= 1'b1;
              state    <= LD_DONE;
            end else begin
              cnt <= cnt + BEAT_W'(1);
            end
          end
        end
        LD_DONE: begin
          ld_done <= 1'b0;
          state   <= LD_IDLE;
        end
        default: begin
          ld_ready <= 1'b0;
          ld_busy  <= 1'b0;
          ld_done  <= 1'b0;
          state    <= LD_IDLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/pattern_bank_ram.sv
// Multi-buffer pattern RAM: combinational PAT read, PAT write port and a wide bulk-load port.
module pattern_bank_ram
  import pat_pkg::*;
#(
  parameter int D_WIDTH      = D_WIDTH_DEF,
  parameter int BUFP_WIDTH   = BUFP_WIDTH_DEF,
  parameter int FIELDP_WIDTH = FIELDP_WIDTH_DEF,
  parameter int LOAD_WIDTH   = LOAD_WIDTH_DEF,
  localparam int ADDR_W      = BUFP_WIDTH + FIELDP_WIDTH,
  localparam int NBUF        = 1 << BUFP_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             buf_fieldp,
  input  logic [ADDR_W-1:0]             buf_fieldwp,
  input  logic                          field_write_en,
  input  logic [D_WIDTH-1:0]            field_in,
  output logic [D_WIDTH-1:0]            field_out,
  input  logic                          ld_start,
  input  logic [BUFP_WIDTH-1:0]         ld_buf,
  input  logic                          ld_valid,
  input  logic [LOAD_WIDTH*D_WIDTH-1:0] ld_data,
  output logic                          ld_ready,
  output logic                          ld_busy,
  output logic                          ld_done,
  output logic [NBUF-1:0]               buf_valid,
  input  logic                          conflict_clr,
  output logic                          wr_conflict
);
  localparam int NENT = 1 << ADDR_W;

  logic [D_WIDTH-1:0]    mem [NENT];
  logic                  start_take, load_we, last_beat, pat_we, conflict;
  logic [ADDR_W-1:0]     load_addr;
  logic [BUFP_WIDTH-1:0] load_buf;
  ld_state_t             ld_state;

  pattern_load_ctrl #(
    .BUFP_WIDTH  (BUFP_WIDTH),
    .FIELDP_WIDTH(FIELDP_WIDTH),
    .LOAD_WIDTH  (LOAD_WIDTH)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .ld_start  (ld_start),
    .ld_buf    (ld_buf),
    .ld_valid  (ld_valid),
    .write_en  (field_write_en),
    .write_buf (buf_fieldwp[ADDR_W-1 -: BUFP_WIDTH]),
    .ld_ready  (ld_ready),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done),
    .start_take(start_take),
    .load_we   (load_we),
    .load_addr (load_addr),
    .last_beat (last_beat),
    .pat_we    (pat_we),
    .conflict  (conflict),
    .load_buf  (load_buf),
    .state     (ld_state)
  );

  assign field_out = mem[buf_fieldp];

  // PAT and load writes never collide: a PAT write into the load buffer is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < NENT; a++) mem[a] <= '0;
    end else begin
      if (pat_we) mem[buf_fieldwp] <= field_in;
      if (load_we) begin
        for (int i = 0; i < LOAD_WIDTH; i++)
          mem[load_addr + ADDR_W'(i)] <= ld_data[i*D_WIDTH +: D_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid   <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (start_take) buf_valid[ld_buf] <= 1'b0;
      if (last_beat && ld_state == LD_LOAD) buf_valid[load_buf] <= 1'b1;
      if (conflict) wr_conflict <= 1'b1;
      else if (conflict_clr) wr_conflict <= 1'b0;
    end
  end
endmodule
